// File: rtl/mdu_unit_if.sv
// mdu_unit_if: request/result bundle between the execute-stage control and the mdu_unit.
interface mdu_unit_if #(
    parameter int unsigned WIDTH = 32
);
    logic             start;
    logic [3:0]       md_op;
    logic [WIDTH-1:0] rs_data;
    logic [WIDTH-1:0] rt_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, md_op, rs_data, rt_data,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, md_op, rs_data, rt_data,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/mdu_unit.sv
// mdu_unit: multi-cycle multiply/divide unit owning HI/LO, with programmable latency.
// Define MDU_MADD_EN to build the madd/maddu/msub/msubu accumulate operations.
module mdu_unit #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input logic       clk,
    input logic       reset,
    mdu_unit_if.slave bus
);
    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam int unsigned DW         = 2 * WIDTH;

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MTHI  = 4'd5;
    localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
    localparam logic [3:0] OP_MADD  = 4'd7;
    localparam logic [3:0] OP_MADDU = 4'd8;
    localparam logic [3:0] OP_MSUB  = 4'd9;
    localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [3:0]       op_q;
    logic             done_q;

    logic [DW-1:0]    prod_s;
    logic [DW-1:0]    prod_u;
    logic [DW-1:0]    quot_rem;
    logic [DW-1:0]    result;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic [WIDTH-1:0] q_mag;
    logic [WIDTH-1:0] r_mag;
    logic             a_neg;
    logic             b_neg;

    // Sign-extended operands give the signed product modulo 2^DW.
    assign prod_s = {{WIDTH{a_q[WIDTH-1]}}, a_q} * {{WIDTH{b_q[WIDTH-1]}}, b_q};
    assign prod_u = {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};

    // Signed divide via magnitudes; most-negative / -1 falls out as MIN rem 0.
    always_comb begin
        a_neg    = (op_q == OP_DIV) & a_q[WIDTH-1];
        b_neg    = (op_q == OP_DIV) & b_q[WIDTH-1];
        dvd_mag  = a_neg ? -a_q : a_q;
        dvs_mag  = b_neg ? -b_q : b_q;
        q_mag    = '0;
        r_mag    = '0;
        quot_rem = {a_q, {WIDTH{1'b1}}};
        if (b_q != '0) begin
            q_mag    = dvd_mag / dvs_mag;
            r_mag    = dvd_mag % dvs_mag;
            quot_rem = {(a_neg ? -r_mag : r_mag), ((a_neg ^ b_neg) ? -q_mag : q_mag)};
        end
    end

    // Value committed to {hi,lo} on the final busy edge.
    always_comb begin
        result = {hi_q, lo_q};
        case (op_q)
            OP_MULT:  result = prod_s;
            OP_MULTU: result = prod_u;
            OP_DIV,
            OP_DIVU:  result = quot_rem;
`ifdef MDU_MADD_EN
            OP_MADD:  result = {hi_q, lo_q} + prod_s;
            OP_MADDU: result = {hi_q, lo_q} + prod_u;
            OP_MSUB:  result = {hi_q, lo_q} - prod_s;
            OP_MSUBU: result = {hi_q, lo_q} - prod_u;
`endif
            default:  result = {hi_q, lo_q};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            cnt    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            op_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    {hi_q, lo_q} <= result;
                    done_q       <= 1'b1;
                end
            end else if (bus.start) begin
                case (bus.md_op)
                    OP_MTHI: begin
                        hi_q   <= bus.rs_data;
                        done_q <= 1'b1;
                    end
                    OP_MTLO: begin
                        lo_q   <= bus.rs_data;
                        done_q <= 1'b1;
                    end
`ifdef MDU_MADD_EN
                    OP_MULT, OP_MULTU, OP_MADD, OP_MADDU, OP_MSUB, OP_MSUBU: begin
`else
                    OP_MULT, OP_MULTU: begin
`endif
                        cnt  <= CNT_W'(MULT_CYCLES);
                        op_q <= bus.md_op;
                        a_q  <= bus.rs_data;
                        b_q  <= bus.rt_data;
                    end
                    OP_DIV, OP_DIVU: begin
                        cnt  <= CNT_W'(DIV_CYCLES);
                        op_q <= bus.md_op;
                        a_q  <= bus.rs_data;
                        b_q  <= bus.rt_data;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.busy = (cnt != '0);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule

// File: tb/tb_mdu_unit.sv
// tb_mdu_unit: directed and randomized checks of mdu_unit against a 64-bit arithmetic model.
module tb_mdu_unit;
    localparam int unsigned W  = 32;
    localparam int unsigned MC = 5;
    localparam int unsigned DC = 10;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;
    logic [31:0] m_hi;
    logic [31:0] m_lo;

    mdu_unit_if #(.WIDTH(W)) bus ();

    mdu_unit #(.WIDTH(W), .MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h required=%h", tag, obs, exp);
        end
    endtask

    // Architectural result of one operation applied to the current {hi,lo}.
    function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [63:0] acc);
        int                sa;
        int                sb;
        longint            sp;
        longint unsigned   ua;
        longint unsigned   ub;
        longint unsigned   up;
        sa = a;
        sb = b;
        sp = longint'(sa) * longint'(sb);
        ua = {32'd0, a};
        ub = {32'd0, b};
        up = ua * ub;
        case (op)
            4'd1: return 64'(sp);
            4'd2: return 64'(up);
            4'd3: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            4'd4: begin
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            4'd5: return {a, acc[31:0]};
            4'd6: return {acc[63:32], a};
`ifdef MDU_MADD_EN
            4'd7:  return acc + 64'(sp);
            4'd8:  return acc + 64'(up);
            4'd9:  return acc - 64'(sp);
            4'd10: return acc - 64'(up);
`endif
            default: return acc;
        endcase
    endfunction

    // Busy cycles expected: -1 no-op, 0 single-cycle move, else latency.
    function automatic int lat_of(input logic [3:0] op);
        case (op)
            4'd1, 4'd2: return int'(MC);
            4'd3, 4'd4: return int'(DC);
            4'd5, 4'd6: return 0;
`ifdef MDU_MADD_EN
            4'd7, 4'd8, 4'd9, 4'd10: return int'(MC);
`endif
            default: return -1;
        endcase
    endfunction

    // Entered and left at a falling edge; chain leaves the bench in the done cycle.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input bit intrude, input bit chain);
        logic [63:0] prev;
        logic [63:0] exp;
        int          lat;
        int          n;
        prev = {m_hi, m_lo};
        exp  = model(op, a, b, prev);
        lat  = lat_of(op);
        bus.start   = 1'b1;
        bus.md_op   = op;
        bus.rs_data = a;
        bus.rt_data = b;
        @(negedge clk);
        bus.start   = 1'b0;
        bus.md_op   = 4'($urandom_range(0, 15));
        bus.rs_data = $urandom;
        bus.rt_data = $urandom;
        if (lat > 0) begin
            n = 0;
            while (bus.busy === 1'b1 && n < 200) begin
                chk({tag, "_hold"}, {bus.hi, bus.lo}, prev);
                chk({tag, "_nodone"}, 64'(bus.done), 64'd0);
                if (intrude && n == 0) begin
                    bus.start   = 1'b1;
                    bus.md_op   = 4'd6;
                    bus.rs_data = 32'h1234;
                end else begin
                    bus.start = 1'b0;
                end
                n++;
                @(negedge clk);
            end
            bus.start = 1'b0;
            chk({tag, "_busy_cycles"}, 64'(n), 64'(lat));
        end else begin
            chk({tag, "_busy_low"}, 64'(bus.busy), 64'd0);
        end
        chk({tag, "_done"}, 64'(bus.done), (lat >= 0) ? 64'd1 : 64'd0);
        chk({tag, "_hilo"}, {bus.hi, bus.lo}, exp);
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        if (!chain) begin
            @(negedge clk);
            chk({tag, "_done_once"}, 64'(bus.done), 64'd0);
            chk({tag, "_hilo_kept"}, {bus.hi, bus.lo}, exp);
        end
    endtask

    initial begin
        logic [3:0]  rop;
        logic [31:0] ra;
        logic [31:0] rb;
        reset       = 1'b0;
        bus.start   = 1'b0;
        bus.md_op   = 4'd0;
        bus.rs_data = '0;
        bus.rt_data = '0;
        m_hi        = '0;
        m_lo        = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_hilo", {bus.hi, bus.lo}, 64'd0);
        chk("reset_busy", 64'(bus.busy), 64'd0);
        chk("reset_done", 64'(bus.done), 64'd0);
        reset = 1'b1;

        run_op("mult", 4'd1, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
        chk("mult_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFF1);
        run_op("multu", 4'd2, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0);
        chk("multu_const", {bus.hi, bus.lo}, 64'h0000_0001_FFFF_FFFE);
        run_op("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        chk("div_neg_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op("divu_zero", 4'd4, 32'd7, 32'd0, 1'b0, 1'b0);
        chk("divu_zero_const", {bus.hi, bus.lo}, 64'h0000_0007_FFFF_FFFF);
        run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("div_ovf_const", {bus.hi, bus.lo}, 64'h0000_0000_8000_0000);
        run_op("mthi", 4'd5, 32'hAAAA_5555, 32'd0, 1'b0, 1'b0);
        chk("mthi_const", 64'(bus.hi), 64'h0000_0000_AAAA_5555);
        run_op("noop0", 4'd0, 32'h1111_2222, 32'h3333_4444, 1'b0, 1'b0);
        run_op("noop15", 4'd15, 32'h1111_2222, 32'h3333_4444, 1'b0, 1'b0);

        // Reset while a divide is in flight: result discarded, no done.
        bus.start   = 1'b1;
        bus.md_op   = 4'd4;
        bus.rs_data = 32'd100;
        bus.rt_data = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mid_busy_before", 64'(bus.busy), 64'd1);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("rst_mid_busy", 64'(bus.busy), 64'd0);
        chk("rst_mid_hilo", {bus.hi, bus.lo}, 64'd0);
        chk("rst_mid_done", 64'(bus.done), 64'd0);
        m_hi = '0;
        m_lo = '0;
        run_op("mult_after_rst", 4'd1, 32'd12345, 32'hFFFF_FF00, 1'b0, 1'b0);

        // Back-to-back: next op issued in the done cycle.
        run_op("chain_a", 4'd2, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b1);
        run_op("chain_b", 4'd6, 32'h0000_00AB, 32'd0, 1'b0, 1'b0);

        // Accumulate family (no-op without MDU_MADD_EN).
        run_op("pre_hi", 4'd5, 32'd0, 32'd0, 1'b0, 1'b0);
        run_op("pre_lo", 4'd6, 32'd10, 32'd0, 1'b0, 1'b0);
        run_op("madd", 4'd7, 32'hFFFF_FFFF, 32'd3, 1'b0, 1'b0);
`ifdef MDU_MADD_EN
        chk("madd_const", {bus.hi, bus.lo}, 64'h0000_0000_0000_0007);
        run_op("msubu", 4'd10, 32'd8, 32'd1, 1'b0, 1'b0);
        chk("msubu_const", {bus.hi, bus.lo}, 64'hFFFF_FFFF_FFFF_FFFF);
`else
        chk("madd_off_const", {bus.hi, bus.lo}, 64'h0000_0000_0000_000A);
`endif

        // Randomized operations against the model.
        for (int i = 0; i < 40; i++) begin
            rop = 4'($urandom_range(0, 15));
            ra  = $urandom;
            rb  = $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(0, 9));
            if ($urandom_range(0, 7) == 0) rb = 32'd0;
            if (rop == 4'd3 && $urandom_range(0, 5) == 0) begin
                ra = 32'h8000_0000;
                rb = 32'hFFFF_FFFF;
            end
            run_op("rand", rop, ra, rb, 1'b0, 1'($urandom_range(0, 1)));
        end
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
